pll_reset_sequencer: RTL

- Sits directly downstream of the 50 MHz PLL wrapper. Consumes its asynchronous `locked` output and drives the PLL's `rst` input.
- Runs on the free-running reference clock, so it stays valid while the PLL is unlocked.
- Sequences PLL reset, lock acquisition, lock-stability qualification and release of the system reset.
- Retries automatically on lock timeout and on loss of lock.

---
 rtl/pll_seq_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_seq_pkg;

    // Sequencer states; the numeric values are visible on state_o.
    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    localparam int REFCLK_HZ             = 50_000_000;
    localparam int DEFAULT_RST_CYCLES    = 16;
    localparam int DEFAULT_LOCK_TIMEOUT  = 50_000;   // 1 ms at REFCLK_HZ
    localparam int DEFAULT_STABLE_CYCLES = 1024;

    // Largest of three terms; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
// Also used to bring sys_rst into the PLL output clock domains.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; q settles two clk edges after d changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification sequencer on the free-running refclk.
// Optional build macro PLL_RESET_SEQ_LOSS_CNT_EN adds a saturating 8-bit
// lock-loss event counter; otherwise lock_loss_cnt is tied to zero.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEFAULT_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEFAULT_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int RETRY_W       = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic [1:0]         state_o,
    output logic [RETRY_W-1:0] retries,
    output logic [7:0]         lock_loss_cnt
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    pll_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_s;
    logic              retry_inc;
    logic              loss_inc;
    logic              pll_rst_d, sys_rst_d, ready_d;

    // pll_locked is asynchronous; nothing else looks at it directly.
    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next state, counter and event strobes; outputs decode from next state
    // so the registered outputs move on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state_q)
            PLL_RESET: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLL_RESET;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s)                 state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d   = PLL_RESET;
                    retry_inc = 1'b1;
                    loss_inc  = 1'b1;
                end
            end
            default: state_d = PLL_RESET;
        endcase
        if (state_d != state_q) cnt_d = '0;

        pll_rst_d = (state_d == PLL_RESET);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
    end

    // State, shared counter and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= PLL_RESET;
            cnt_q   <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pll_rst <= pll_rst_d;
            sys_rst <= sys_rst_d;
            ready   <= ready_d;
        end
    end

    // Saturating count of timeouts plus lock losses.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst)                          retries <= '0;
        else if (retry_inc && ~&retries)  retries <= retries + 1'b1;
    end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    // Saturating count of RUN -> PLL_RESET lock-loss events.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst)                              lock_loss_cnt <= 8'd0;
        else if (loss_inc && ~&lock_loss_cnt) lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
`else
    // Feature not built: port kept, value fixed at zero.
    assign lock_loss_cnt = 8'd0;
    logic unused_loss;
    assign unused_loss = loss_inc;
`endif

    assign state_o = state_q;

endmodule
